// File: rtl/trace_bist_ctrl.sv
// BIST sequencer/arbiter for the mips_16 data-memory / trace-compactor port.
// Passes the CPU through when idle; otherwise clears, sweeps and signs off the compactor.
module trace_bist_ctrl #(
    parameter int          ADDR_W = 8,
    parameter logic [15:0] SEED   = 16'hA5A5,
    parameter logic [15:0] GOLDEN = 16'h0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_bist_start,
    input  logic [15:0] i_cpu_addr,
    input  logic [15:0] i_cpu_wdata,
    input  logic        i_cpu_we,
    output logic        o_cpu_stall,
    output logic [15:0] o_mem_addr,
    output logic [15:0] o_mem_wdata,
    output logic        o_mem_we,
    output logic        o_ora_clr,
    input  logic [15:0] i_sig_in,
    output logic        o_bist_busy,
    output logic        o_bist_done,
    output logic        o_bist_pass,
    output logic [15:0] o_bist_sig
);

    // state | meaning
    // IDLE  | CPU owns the port, waiting for bist_start
    // CLEAR | compactor clear pulse, CPU stalled
    // SWEEP | 2^ADDR_W pattern writes, cnt = address
    // DRAIN | last write settled, capture signature and verdict
    // DONE  | one-cycle done pulse, CPU released
    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_SWEEP,
        S_DRAIN,
        S_DONE
    } state_t;

    localparam logic [ADDR_W-1:0] CNT_LAST = '1;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [ADDR_W-1:0] r_cnt;
    logic [ADDR_W-1:0] w_cnt_nxt;
    logic              r_pass;
    logic [15:0]       r_sig;
    logic [7:0]        w_cnt8;

    assign w_cnt8 = 8'(r_cnt);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_pass  <= 1'b0;
            r_sig   <= 16'h0000;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (r_state == S_DRAIN) begin
                r_sig  <= i_sig_in;
                r_pass <= (i_sig_in == GOLDEN);
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        o_mem_addr  = i_cpu_addr;
        o_mem_wdata = i_cpu_wdata;
        o_mem_we    = i_cpu_we;
        o_ora_clr   = 1'b0;
        o_bist_busy = 1'b0;
        o_bist_done = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_bist_start) w_state_nxt = S_CLEAR;
            end
            S_CLEAR: begin
                o_ora_clr   = 1'b1;
                o_bist_busy = 1'b1;
                o_mem_addr  = 16'h0000;
                o_mem_wdata = 16'h0000;
                o_mem_we    = 1'b0;
                w_cnt_nxt   = '0;
                w_state_nxt = S_SWEEP;
            end
            S_SWEEP: begin
                o_bist_busy = 1'b1;
                o_mem_addr  = 16'(r_cnt);
                o_mem_wdata = {w_cnt8, w_cnt8} ^ SEED;
                o_mem_we    = 1'b1;
                // natural wrap brings cnt back to 0 on the last write
                w_cnt_nxt   = r_cnt + 1'b1;
                if (r_cnt == CNT_LAST) w_state_nxt = S_DRAIN;
            end
            S_DRAIN: begin
                o_bist_busy = 1'b1;
                o_mem_addr  = 16'h0000;
                o_mem_wdata = 16'h0000;
                o_mem_we    = 1'b0;
                w_state_nxt = S_DONE;
            end
            S_DONE: begin
                o_bist_done = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign o_cpu_stall = o_bist_busy;
    assign o_bist_pass = r_pass;
    assign o_bist_sig  = r_sig;

endmodule
